pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit.sv | 128 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// PC fetch unit: BOOT/RUN/HALT sequencer with branch/jump next-PC selection.
// Optional performance counters are built when PERF_CNT_EN is defined.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [31:0] instr,
    input  logic        Branch,
    input  logic        BNE,
    input  logic        Jump,
    input  logic        zero,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        valid,
    output logic        halted,
    output logic [31:0] retired_cnt,
    output logic [31:0] taken_cnt
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;

    logic        is_halt;
    logic        br_taken;
    logic [31:0] br_offset;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] next_pc;

    assign pc       = pc_q;
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        is_halt   = (instr == HALT_WORD);
        br_taken  = Branch & (zero ^ BNE);
        br_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
        br_target = pc_plus4 + br_offset;
        j_target  = {pc_plus4[31:28], instr[25:0], 2'b00};
        if (Jump) begin
            next_pc = j_target;
        end else if (br_taken) begin
            next_pc = br_target;
        end else begin
            next_pc = pc_plus4;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid   = 1'b0;
        halted  = 1'b0;
        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!stall) begin
                    if (is_halt) begin
                        state_d = ST_HALT;
                    end else begin
                        valid = 1'b1;
                        pc_d  = next_pc;
                    end
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

`ifdef PERF_CNT_EN
    logic [31:0] retired_q, retired_d;
    logic [31:0] taken_q, taken_d;

    // valid already folds in RUN, stall and the halt word
    always_comb begin
        retired_d = retired_q;
        taken_d   = taken_q;
        if (valid) begin
            retired_d = retired_q + 32'd1;
            if (Jump | br_taken) begin
                taken_d = taken_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= 32'd0;
            taken_q   <= 32'd0;
        end else begin
            retired_q <= retired_d;
            taken_q   <= taken_d;
        end
    end

    assign retired_cnt = retired_q;
    assign taken_cnt   = taken_q;
`else
    assign retired_cnt = 32'd0;
    assign taken_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus
// randomized traffic against a behavioural fetch model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] HALTW  = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic [31:0] instr = NOP;
    logic        Branch = 1'b0;
    logic        BNE = 1'b0;
    logic        Jump = 1'b0;
    logic        zero = 1'b0;
    logic [31:0] pc, pc_plus4, retired_cnt, taken_cnt;
    logic        valid, halted;

    pc_fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .instr(instr),
        .Branch(Branch), .BNE(BNE), .Jump(Jump), .zero(zero),
        .pc(pc), .pc_plus4(pc_plus4), .valid(valid), .halted(halted),
        .retired_cnt(retired_cnt), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // model: m_mode 0 = just reset (boot cycle), 1 = running, 2 = stopped
    bit          m_known = 1'b0;
    int          m_mode;
    logic [31:0] m_pc, m_ret, m_tkn;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_exec();
        return (m_mode == 1) && !stall && (instr != HALTW);
    endfunction

    function automatic bit m_taken();
        return Jump || (Branch && (zero != BNE));
    endfunction

    task automatic check_outputs();
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("valid", {31'd0, valid}, {31'd0, m_exec()});
        chk("halted", {31'd0, halted}, {31'd0, (m_mode == 2)});
        chk("retired", retired_cnt, PERF ? m_ret : 32'd0);
        chk("taken", taken_cnt, PERF ? m_tkn : 32'd0);
    endtask

    task automatic model_step();
        logic [31:0] np4, np;
        int          sx;
        if (rst) begin
            m_known = 1'b1;
            m_mode  = 0;
            m_pc    = RST_PC;
            m_ret   = 0;
            m_tkn   = 0;
        end else if (!m_known) begin
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1 && !stall) begin
            if (instr == HALTW) begin
                m_mode = 2;
            end else begin
                np4 = m_pc + 32'd4;
                sx  = int'($signed(instr[15:0]));
                if (Jump)
                    np = (np4 & 32'hF000_0000) + (instr % (32'd1 << 26)) * 32'd4;
                else if (Branch && (zero != BNE))
                    np = np4 + 32'(sx * 4);
                else
                    np = np4;
                m_ret = m_ret + 1;
                if (m_taken()) m_tkn = m_tkn + 1;
                m_pc = np;
            end
        end
    endtask

    task automatic tick();
        #2;
        if (m_known) check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic b, input logic n,
                         input logic j, input logic z, input logic s);
        instr = i; Branch = b; BNE = n; Jump = j; zero = z; stall = s;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(NOP, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // sequential fetch
        do_reset();
        tick();
        chk("boot_pc", pc, RST_PC);
        repeat (3) tick();
        #2;
        chk("seq_pc12", pc, 32'd12);
        chk("seq_ret3", retired_cnt, PERF ? 32'd3 : 32'd0);

        // beq taken / not taken around pc=8
        do_reset();
        repeat (3) tick();
        drive(32'h0000_FFFE, 1, 0, 0, 1, 0);
        tick();
        drive(NOP, 0, 0, 0, 0, 0);
        tick();
        #2;
        chk("beq_nt_at8", pc, 32'd8);
        drive(32'h0000_FFFE, 1, 0, 0, 0, 0);
        tick();
        #2;
        chk("beq_nt", pc, 32'd12);

        // jump to 16, bne to 32
        drive(32'h0000_0004, 0, 0, 1, 0, 0);
        tick();
        drive(32'h0000_0003, 1, 1, 0, 0, 0);
        tick();
        #2;
        chk("bne_32", pc, 32'd32);

        // climb into the 0x1 region, then jump with Branch also set
        drive(32'h03FF_FFFF, 0, 0, 1, 0, 0);
        tick();
        drive(32'h0000_0000, 0, 0, 1, 0, 0);
        tick();
        #2;
        chk("j_region", pc, 32'h1000_0000);
        drive(32'h0000_0040, 1, 0, 1, 1, 0);
        tick();
        #2;
        chk("j_over_br", pc, 32'h1000_0100);

        // wrap: branch back from 0 to FFFF_FFFC, then advance to 0
        do_reset();
        tick();
        drive(32'h0000_FFFE, 1, 0, 0, 1, 0);
        tick();
        #2;
        chk("wrap_top", pc, 32'hFFFF_FFFC);
        drive(NOP, 0, 0, 0, 0, 0);
        tick();
        #2;
        chk("wrap_zero", pc, 32'h0);

        // stall at pc=20 with a pending jump to 40
        drive(32'h0000_0005, 0, 0, 1, 0, 0);
        tick();
        drive(32'h0000_000A, 0, 0, 1, 0, 1);
        repeat (2) tick();
        #2;
        chk("stall_pc", pc, 32'd20);
        drive(32'h0000_000A, 0, 0, 1, 0, 0);
        tick();
        #2;
        chk("stall_jump", pc, 32'd40);

        // halt at 40, random inputs must be ignored
        drive(HALTW, 0, 0, 0, 0, 0);
        tick();
        for (int k = 0; k < 10; k++) begin
            drive($urandom, 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom));
            tick();
        end
        #2;
        chk("halt_pc", pc, 32'd40);
        chk("halt_flag", {31'd0, halted}, 32'd1);
        do_reset();
        #2;
        chk("rst_pc", pc, RST_PC);
        chk("rst_ret", retired_cnt, 32'd0);
        chk("rst_boot_valid", {31'd0, valid}, 32'd0);

        // random traffic with occasional halt words and resets
        for (int k = 0; k < 600; k++) begin
            rst = ($urandom_range(0, 39) == 0);
            drive(($urandom_range(0, 29) == 0) ? HALTW : $urandom,
                  1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                  1'($urandom), ($urandom_range(0, 4) == 0));
            tick();
        end
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
